countdown_timer: RTL and testbench

Down-counting minutes:seconds timer, the decrementing counterpart of the seconds/minutes up-counters in the clock design. It is loaded with an MM:SS value, counts down one second per prescaled tick, and signals expiry with a one-cycle borrow pulse and an optional held alarm. It sits beside the time-of-day counter chain and shares its `clock` and the 6-bit BCD-free binary field format.

---
 rtl/clock_pkg.sv | 10 +
 rtl/down_counter_mod60.sv | 22 ++
 rtl/countdown_timer.sv | 115 +++++++++++
 tb/tb_countdown_timer.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// clock_pkg: shared state encoding, field limits and time-field type for the clock/timer blocks.
package clock_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
  typedef logic [5:0] tfield_t;
  localparam tfield_t SEC_MAX = 6'd59;
  localparam tfield_t MIN_MAX = 6'd59;
  function automatic tfield_t clamp_field(input tfield_t v, input tfield_t max);
    return (v > max) ? max : v;
  endfunction
endpackage

// File: rtl/down_counter_mod60.sv
// down_counter_mod60: loadable modulo-60 down counter; borrow flags a decrement out of zero.
module down_counter_mod60
  import clock_pkg::*;
#(
  parameter tfield_t MAX = SEC_MAX
) (
  input  logic    clock,
  input  logic    reset_tmr,
  input  logic    load,
  input  tfield_t data,
  input  logic    dec,
  output tfield_t count,
  output logic    borrow
);
  tfield_t r_count;
  always_ff @(posedge clock)
    if (!reset_tmr) r_count <= '0;
    else if (load) r_count <= clamp_field(data, MAX);
    else if (dec) r_count <= (r_count == '0) ? MAX : r_count - 6'd1;
  assign count  = r_count;
  assign borrow = dec && (r_count == '0);
endmodule

// File: rtl/countdown_timer.sv
// countdown_timer: MM:SS down-counting timer with prescaler, run/pause FSM and expiry pulse.
// Define COUNTDOWN_ALARM_EN to add the held alarm_tmr output and its hold counter.
module countdown_timer
  import clock_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000
`ifdef COUNTDOWN_ALARM_EN
  , parameter int ALARM_CYCLES = 100_000_000
`endif
) (
  input  logic       clock,
  input  logic       reset_tmr,
  input  logic [5:0] data_min,
  input  logic [5:0] data_sec,
  input  logic       load_tmr,
  input  logic       enable_tmr,
  output logic [5:0] count_min,
  output logic [5:0] count_sec,
  output logic       borrow_tmr,
  output logic       running_tmr
`ifdef COUNTDOWN_ALARM_EN
  , output logic     alarm_tmr
`endif
);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
  state_t        r_state;
  logic [PW-1:0] r_presc;
  logic          r_borrow, r_running;
  tfield_t       w_min, w_sec;
  logic          w_tick, w_last, w_zero, w_sec_borrow, w_min_borrow_unused;
  // A tick needs enable so a pause edge never consumes the final prescaler step.
  assign w_tick = (r_state == RUN) && enable_tmr && !load_tmr && (r_presc == P_LAST);
  assign w_zero = (w_min == '0) && (w_sec == '0);
  assign w_last = w_tick && (w_min == '0) && (w_sec == 6'd1);
  down_counter_mod60 #(.MAX(SEC_MAX)) u_sec (
    .clock    (clock),
    .reset_tmr(reset_tmr),
    .load     (load_tmr),
    .data     (data_sec),
    .dec      (w_tick),
    .count    (w_sec),
    .borrow   (w_sec_borrow)
  );
  // Minutes never underflow because 00:00 is terminal, so their borrow goes nowhere.
  down_counter_mod60 #(.MAX(MIN_MAX)) u_min (
    .clock    (clock),
    .reset_tmr(reset_tmr),
    .load     (load_tmr),
    .data     (data_min),
    .dec      (w_sec_borrow),
    .count    (w_min),
    .borrow   (w_min_borrow_unused)
  );
  always_ff @(posedge clock)
    if (!reset_tmr || load_tmr) begin
      r_state   <= IDLE;
      r_presc   <= '0;
      r_borrow  <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_borrow <= w_last;
      case (r_state)
        IDLE:
          if (enable_tmr && !w_zero) begin
            r_state   <= RUN;
            r_running <= 1'b1;
          end
        RUN:
          if (!enable_tmr) begin
            r_state   <= PAUSE;
            r_running <= 1'b0;
          end else if (w_tick) begin
            r_presc <= '0;
            if (w_last) begin
              r_state   <= DONE;
              r_running <= 1'b0;
            end
          end else r_presc <= r_presc + 1'b1;
        PAUSE:
          if (enable_tmr) begin
            r_state   <= RUN;
            r_running <= 1'b1;
          end
        default: r_state <= DONE;
      endcase
    end
  assign count_min   = w_min;
  assign count_sec   = w_sec;
  assign borrow_tmr  = r_borrow;
  assign running_tmr = r_running;
`ifdef COUNTDOWN_ALARM_EN
  localparam int AW = $clog2(ALARM_CYCLES + 1);
  logic          r_alarm, r_en_q;
  logic [AW-1:0] r_acnt;
  // A falling enable acts as operator acknowledge and drops the alarm early.
  always_ff @(posedge clock)
    if (!reset_tmr) begin
      r_alarm <= 1'b0;
      r_en_q  <= 1'b0;
      r_acnt  <= '0;
    end else begin
      r_en_q <= enable_tmr;
      if (load_tmr || (r_en_q && !enable_tmr)) r_alarm <= 1'b0;
      else if (w_last) begin
        r_alarm <= 1'b1;
        r_acnt  <= '0;
      end else if (r_alarm) begin
        r_alarm <= (r_acnt != AW'(ALARM_CYCLES - 1));
        r_acnt  <= r_acnt + 1'b1;
      end
    end
  assign alarm_tmr = r_alarm;
`endif
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed scoreboard bench; expectations are queued with their due cycle.
module tb_countdown_timer;
  localparam int TD = 4;
`ifdef COUNTDOWN_ALARM_EN
  localparam bit AL = 1'b1;
`else
  localparam bit AL = 1'b0;
`endif
  logic        clock = 1'b0;
  logic        reset_tmr, load_tmr, enable_tmr;
  logic [5:0]  data_min, data_sec, count_min, count_sec;
  logic        borrow_tmr, running_tmr, alarm_o;
  logic [14:0] obs;
  int          cyc = 0;
  int          n_asserts = 0;
  int          n_fail = 0;
  typedef struct {
    int          at;
    string       tag;
    logic [14:0] v;
  } exp_t;
  exp_t q[$];
  exp_t e;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  countdown_timer #(
    .TICK_DIV(TD)
`ifdef COUNTDOWN_ALARM_EN
    , .ALARM_CYCLES(8)
`endif
  ) dut (
    .clock      (clock),
    .reset_tmr  (reset_tmr),
    .data_min   (data_min),
    .data_sec   (data_sec),
    .load_tmr   (load_tmr),
    .enable_tmr (enable_tmr),
    .count_min  (count_min),
    .count_sec  (count_sec),
    .borrow_tmr (borrow_tmr),
    .running_tmr(running_tmr)
`ifdef COUNTDOWN_ALARM_EN
    , .alarm_tmr(alarm_o)
`endif
  );
`ifndef COUNTDOWN_ALARM_EN
  assign alarm_o = 1'b0;
`endif
  assign obs = {count_min, count_sec, borrow_tmr, running_tmr, alarm_o};

  always @(negedge clock)
    while (q.size() > 0 && q[0].at == cyc) begin
      e = q.pop_front();
      n_asserts++;
      assert (obs === e.v) else begin
        n_fail++;
        $error("FAIL %s cyc %0d: observed %0d:%0d b=%b r=%b a=%b, expected %0d:%0d b=%b r=%b a=%b",
               e.tag, cyc, obs[14:9], obs[8:3], obs[2], obs[1], obs[0],
               e.v[14:9], e.v[8:3], e.v[2], e.v[1], e.v[0]);
      end
    end

  task automatic expect_at(input int dc, input string tag, input int mn, input int sc,
                           input bit b, input bit r, input bit a);
    exp_t x;
    x.at  = cyc + dc;
    x.tag = tag;
    x.v   = {mn[5:0], sc[5:0], b, r, a};
    q.push_back(x);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic drive(input bit ld, input int mn, input int sc, input bit en);
    load_tmr   = ld;
    data_min   = 6'(mn);
    data_sec   = 6'(sc);
    enable_tmr = en;
  endtask

  initial begin
    reset_tmr = 1'b0;
    drive(1, 5, 30, 1);
    step(2);
    expect_at(1, "reset_hold", 0, 0, 0, 0, 0);
    step(1);
    reset_tmr = 1'b1;
    drive(0, 5, 30, 1);
    expect_at(1, "post_reset", 0, 0, 0, 0, 0);
    expect_at(3, "idle_zero", 0, 0, 0, 0, 0);
    step(3);
    // 01:02 with load and enable on the same edge, then the seconds wrap
    drive(1, 1, 2, 1);
    expect_at(1, "load_0102", 1, 2, 0, 0, 0);
    step(1);
    drive(0, 1, 2, 1);
    expect_at(1, "run_entry", 1, 2, 0, 1, 0);
    expect_at(4, "pre_tick", 1, 2, 0, 1, 0);
    expect_at(5, "dec_0101", 1, 1, 0, 1, 0);
    expect_at(9, "dec_0100", 1, 0, 0, 1, 0);
    expect_at(13, "wrap_0059", 0, 59, 0, 1, 0);
    step(13);
    // 00:02 to expiry, then frozen in DONE with enable still high
    drive(1, 0, 2, 1);
    expect_at(1, "load_0002", 0, 2, 0, 0, 0);
    step(1);
    drive(0, 0, 2, 1);
    expect_at(1, "run_0002", 0, 2, 0, 1, 0);
    expect_at(5, "dec_0001", 0, 1, 0, 1, 0);
    expect_at(8, "pre_final", 0, 1, 0, 1, 0);
    expect_at(9, "expire", 0, 0, 1, 0, AL);
    expect_at(10, "borrow_once", 0, 0, 0, 0, AL);
    expect_at(16, "alarm_last", 0, 0, 0, 0, AL);
    expect_at(17, "alarm_off", 0, 0, 0, 0, 0);
    expect_at(30, "done_hold", 0, 0, 0, 0, 0);
    step(30);
    // pause with the prescaler at 2, resume two cycles from the next tick
    drive(1, 0, 10, 1);
    expect_at(1, "load_0010", 0, 10, 0, 0, 0);
    step(1);
    drive(0, 0, 10, 1);
    expect_at(1, "run_0010", 0, 10, 0, 1, 0);
    step(3);
    drive(0, 0, 10, 0);
    expect_at(1, "pause", 0, 10, 0, 0, 0);
    expect_at(19, "paused", 0, 10, 0, 0, 0);
    step(20);
    drive(0, 0, 10, 1);
    expect_at(1, "resume", 0, 10, 0, 1, 0);
    expect_at(2, "resume_hold", 0, 10, 0, 1, 0);
    expect_at(3, "resume_dec", 0, 9, 0, 1, 0);
    step(3);
    // clamp of out-of-range load values
    drive(1, 63, 60, 0);
    expect_at(1, "clamp", 59, 59, 0, 0, 0);
    step(1);
    drive(0, 63, 60, 0);
    expect_at(2, "clamp_idle", 59, 59, 0, 0, 0);
    step(2);
    // 00:00 with enable stays idle and never borrows
    drive(1, 0, 0, 1);
    expect_at(1, "zero_load", 0, 0, 0, 0, 0);
    step(1);
    drive(0, 0, 0, 1);
    expect_at(1, "zero_stay", 0, 0, 0, 0, 0);
    expect_at(5, "zero_idle", 0, 0, 0, 0, 0);
    step(5);
    // expiry then enable dropped in the third alarm cycle
    drive(1, 0, 1, 1);
    expect_at(1, "load_0001", 0, 1, 0, 0, 0);
    step(1);
    drive(0, 0, 1, 1);
    expect_at(1, "run_0001", 0, 1, 0, 1, 0);
    expect_at(5, "expire2", 0, 0, 1, 0, AL);
    expect_at(7, "alarm_c3", 0, 0, 0, 0, AL);
    step(7);
    drive(0, 0, 1, 0);
    expect_at(1, "alarm_ack", 0, 0, 0, 0, 0);
    expect_at(4, "ack_hold", 0, 0, 0, 0, 0);
    step(4);
    for (int i = 0; i < 20 && q.size() > 0; i++) step(1);
    n_asserts++;
    assert (q.size() == 0) else begin
      n_fail++;
      $error("FAIL drain: %0d expectations unconsumed, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
